uart_rx_frame_ctrl: RTL and testbench

Sequencer between the UART RX frame FIFO and the APB read path. It pops one raw 12-bit frame word per transaction and decodes it according to the latched frame configuration (data width, parity, stop bits). It checks the start, parity and stop bits, then presents 8-bit data plus error flags through a valid/ready holding stage. It also runs the RX idle-timeout counter and generates the rx_done pulse consumed by the APB status logic.

---
 rtl/uart_rx_pkg.sv | 33 +++
 rtl/uart_rx_frame_decode.sv | 42 ++++
 rtl/uart_rx_frame_ctrl.sv | 136 +++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================
// uart_rx_pkg - shared types for the UART RX frame path, rev 1.0
// ============================================================
package uart_rx_pkg;

  localparam int FRAME_W_DEF = 12;
  localparam int DATA_W_DEF  = 8;
  localparam int START_POS   = 0;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    DEC  = 3'd3,
    HOLD = 3'd4
  } rx_state_e;

  typedef struct packed {
    logic [3:0] data_bits;
    logic       parity_en;
    logic       parity_odd;
    logic       stop2;
  } rx_cfg_t;

  typedef struct packed {
    logic start;
    logic parity;
    logic stop;
  } rx_err_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_frame_decode.sv
`default_nettype none
// ============================================================
// uart_rx_frame_decode - combinational raw frame to data/error decode, rev 1.0
// ============================================================
module uart_rx_frame_decode
  import uart_rx_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic [FRAME_W-1:0] frame,
  input  rx_cfg_t            cfg,
  output logic [DATA_W-1:0]  data,
  output rx_err_t            err
);

  localparam int IW = $clog2(FRAME_W);

  logic [IW-1:0] n_bits;
  logic [IW-1:0] par_pos;
  logic [IW-1:0] stop_pos;
  logic          par_calc;

  always_comb begin
    // Out-of-range widths fall back to the full data width
    n_bits = IW'(DATA_W);
    if (cfg.data_bits >= 4'd5 && cfg.data_bits < 4'd8) begin
      n_bits = IW'(cfg.data_bits);
    end
    par_pos  = n_bits + IW'(1);
    stop_pos = par_pos + IW'(cfg.parity_en);

    data     = DATA_W'(frame >> 1) & ~({DATA_W{1'b1}} << n_bits);
    par_calc = (^data) ^ frame[par_pos];

    err.start  = frame[START_POS];
    err.parity = cfg.parity_en & (par_calc != cfg.parity_odd);
    err.stop   = ~frame[stop_pos] | (cfg.stop2 & ~frame[stop_pos + IW'(1)]);
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================
// uart_rx_frame_ctrl - RX FIFO pop/decode sequencer with idle timeout, rev 1.0
// ============================================================
module uart_rx_frame_ctrl
  import uart_rx_pkg::*;
#(
  parameter int FRAME_W     = FRAME_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               PCLK,
  input  logic               PRESET,
  input  logic               enable,
  input  logic [3:0]         cfg_data_bits,
  input  logic               cfg_parity_en,
  input  logic               cfg_parity_odd,
  input  logic               cfg_stop2,
  input  logic               fifo_not_empty,
  output logic               fifo_rd_en,
  input  logic [FRAME_W-1:0] fifo_rd_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_err_start,
  output logic               out_err_parity,
  output logic               out_err_stop,
  output logic               rx_done,
  output logic               timeout_flag,
  output logic               busy
);

  localparam int                CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYC);

  rx_state_e          state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  rx_cfg_t            cfg_q, cfg_d;
  logic [DATA_W-1:0]  data_q, data_d;
  rx_err_t            err_q, err_d;
  logic               rx_done_q, rx_done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               armed_q, armed_d;
  logic               accept;
  logic [DATA_W-1:0]  dec_data;
  rx_err_t            dec_err;

  uart_rx_frame_decode #(
    .FRAME_W (FRAME_W),
    .DATA_W  (DATA_W)
  ) u_decode (
    .frame (frame_q),
    .cfg   (cfg_q),
    .data  (dec_data),
    .err   (dec_err)
  );

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    cfg_d   = cfg_q;
    data_d  = data_q;
    err_d   = err_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: if (enable && fifo_not_empty) state_d = RD;
      RD: begin
        cfg_d   = '{data_bits: cfg_data_bits, parity_en: cfg_parity_en,
                    parity_odd: cfg_parity_odd, stop2: cfg_stop2};
        state_d = CAP;
      end
      CAP: begin
        frame_d = fifo_rd_data;
        state_d = DEC;
      end
      DEC: begin
        data_d  = dec_data;
        err_d   = dec_err;
        state_d = HOLD;
      end
      HOLD: if (out_ready) begin
        accept  = 1'b1;
        state_d = (enable && fifo_not_empty) ? RD : IDLE;
      end
      default: state_d = IDLE;
    endcase
    rx_done_d = accept;

    // Idle timer only runs after a frame was handed over and the FIFO stays dry
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (state_q == RD || !enable) begin
      cnt_d   = '0;
      armed_d = 1'b0;
    end else begin
      if (accept) armed_d = 1'b1;
      if (armed_q && state_q == IDLE && !fifo_not_empty && cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      cfg_q     <= '0;
      data_q    <= '0;
      err_q     <= '0;
      rx_done_q <= 1'b0;
      cnt_q     <= '0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      cfg_q     <= cfg_d;
      data_q    <= data_d;
      err_q     <= err_d;
      rx_done_q <= rx_done_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
    end
  end

  assign fifo_rd_en     = (state_q == RD);
  assign out_valid      = (state_q == HOLD);
  assign busy           = (state_q != IDLE);
  assign out_data       = data_q;
  assign out_err_start  = err_q.start;
  assign out_err_parity = err_q.parity;
  assign out_err_stop   = err_q.stop;
  assign rx_done        = rx_done_q;
  assign timeout_flag   = (cnt_q == CNT_MAX);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================
// tb_uart_rx_frame_ctrl - self-checking bench for uart_rx_frame_ctrl, rev 1.0
// ============================================================
module tb_uart_rx_frame_ctrl;

  localparam int FRAME_W = 12;
  localparam int DATA_W  = 8;
  localparam int TMO     = 16;

  logic               PCLK = 1'b0;
  logic               PRESET;
  logic               enable;
  logic [3:0]         cfg_data_bits;
  logic               cfg_parity_en;
  logic               cfg_parity_odd;
  logic               cfg_stop2;
  logic               fifo_not_empty = 1'b0;
  logic               fifo_rd_en;
  logic [FRAME_W-1:0] fifo_rd_data = '0;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic               out_err_start;
  logic               out_err_parity;
  logic               out_err_stop;
  logic               rx_done;
  logic               timeout_flag;
  logic               busy;

  uart_rx_frame_ctrl #(
    .FRAME_W     (FRAME_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .PCLK           (PCLK),
    .PRESET         (PRESET),
    .enable         (enable),
    .cfg_data_bits  (cfg_data_bits),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .cfg_stop2      (cfg_stop2),
    .fifo_not_empty (fifo_not_empty),
    .fifo_rd_en     (fifo_rd_en),
    .fifo_rd_data   (fifo_rd_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_err_start  (out_err_start),
    .out_err_parity (out_err_parity),
    .out_err_stop   (out_err_stop),
    .rx_done        (rx_done),
    .timeout_flag   (timeout_flag),
    .busy           (busy)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [11:0] word;
    logic [3:0]  bits;
    logic        pen;
    logic        podd;
    logic        stop2;
    logic [7:0]  data;
    logic        e_start;
    logic        e_par;
    logic        e_stop;
  } vec_t;

  typedef struct packed {
    logic [7:0] data;
    logic       e_start;
    logic       e_par;
    logic       e_stop;
  } exp_t;

  localparam int NVEC = 7;
  vec_t vecs[NVEC];

  exp_t        sb[$];
  logic [11:0] fq[$];
  logic        push_req  = 1'b0;
  logic [11:0] push_word = '0;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   rd_cnt = 0;
  int   rd_cyc = 0;
  int   base   = 0;
  logic prev_valid = 1'b0;
  logic stable;

  // FIFO model: read data appears the cycle after the pop strobe
  always @(posedge PCLK) begin
    if (fifo_rd_en && fq.size() != 0) fifo_rd_data <= fq.pop_front();
    if (push_req) fq.push_back(push_word);
    fifo_not_empty <= (fq.size() != 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: score the handshake the coming edge will take, then sample at negedge
  task automatic tick();
    logic acc;
    exp_t e;
    acc = out_valid && out_ready && !PRESET;
    if (acc) begin
      chk("frame_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("frame", 32'({out_data, out_err_start, out_err_parity, out_err_stop}), 32'(e));
      end
    end
    @(negedge PCLK);
    cyc++;
    chk("rx_done", 32'(rx_done), 32'(acc));
    if (fifo_rd_en) begin
      rd_cnt++;
      rd_cyc = cyc;
    end
    if (out_valid && !prev_valid) chk("latency", 32'(cyc - rd_cyc), 32'd3);
    prev_valid = out_valid;
  endtask

  task automatic push(input logic [11:0] w);
    push_req  = 1'b1;
    push_word = w;
    tick();
    push_req  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 60) begin
      tick();
      n++;
    end
    chk(name, 32'({sb.size() != 0, busy}), 32'd0);
  endtask

  task automatic wait_rd();
    int n = 0;
    while (!fifo_rd_en && n < 20) begin
      tick();
      n++;
    end
    chk("wait_rd", 32'(fifo_rd_en), 32'd1);
  endtask

  task automatic set_cfg(input logic [3:0] b, input logic pen, input logic podd, input logic s2);
    cfg_data_bits  = b;
    cfg_parity_en  = pen;
    cfg_parity_odd = podd;
    cfg_stop2      = s2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{12'h34A, 4'd8, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{12'h54A, 4'd8, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{12'h74A, 4'd8, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{12'h1AA, 4'd5, 1'b1, 1'b1, 1'b1, 8'h15, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{12'h0AA, 4'd5, 1'b1, 1'b1, 1'b1, 8'h15, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{12'h34B, 4'd8, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{12'h2F0, 4'd3, 1'b0, 1'b0, 1'b0, 8'h78, 1'b0, 1'b0, 1'b0};

    PRESET    = 1'b1;
    enable    = 1'b0;
    out_ready = 1'b0;
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge PCLK);
    chk("reset_outputs", 32'({out_valid, fifo_rd_en, busy, rx_done, timeout_flag,
                              out_err_start, out_err_parity, out_err_stop, out_data}), 32'd0);
    PRESET = 1'b0;
    enable = 1'b1;

    repeat (20) tick();
    chk("no_timeout_before_frame", 32'(timeout_flag), 32'd0);

    out_ready = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      set_cfg(vecs[i].bits, vecs[i].pen, vecs[i].podd, vecs[i].stop2);
      sb.push_back({vecs[i].data, vecs[i].e_start, vecs[i].e_par, vecs[i].e_stop});
      base = rd_cnt;
      push(vecs[i].word);
      drain("vec_drain");
      chk("vec_pops", 32'(rd_cnt - base), 32'd1);
    end

    // Back-pressure: two queued words, consumer stalls on the first
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    sb.push_back({8'hA5, 3'b000});
    sb.push_back({8'h78, 3'b000});
    base = rd_cnt;
    push(12'h34A);
    push(12'h2F0);
    stable = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (out_valid && out_data !== 8'hA5) stable = 1'b0;
    end
    chk("hold_valid", 32'(out_valid), 32'd1);
    chk("hold_stable", 32'(stable), 32'd1);
    chk("hold_pops", 32'(rd_cnt - base), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("repop_next_cycle", 32'(fifo_rd_en), 32'd1);
    drain("b2b_drain");
    chk("b2b_pops", 32'(rd_cnt - base), 32'd2);

    // Idle timeout after an accepted frame; first sample is idle cycle 1
    sb.push_back({8'hA5, 3'b000});
    push(12'h34A);
    drain("tmo_frame");
    repeat (15) tick();
    chk("tmo_before_16", 32'(timeout_flag), 32'd0);
    tick();
    chk("tmo_at_16", 32'(timeout_flag), 32'd1);
    repeat (10) tick();
    chk("tmo_saturated", 32'(timeout_flag), 32'd1);
    sb.push_back({8'hA5, 3'b000});
    push(12'h34A);
    wait_rd();
    tick();
    chk("tmo_clear_on_pop", 32'(timeout_flag), 32'd0);
    drain("tmo_drain");
    repeat (17) tick();
    chk("tmo_again", 32'(timeout_flag), 32'd1);
    enable = 1'b0;
    tick();
    chk("tmo_clear_on_disable", 32'(timeout_flag), 32'd0);
    enable = 1'b1;

    // Reset while in CAP
    sb.push_back({8'hA5, 3'b000});
    push(12'h34A);
    wait_rd();
    tick();
    PRESET = 1'b1;
    #1;
    chk("rst_cap_outputs", 32'({out_valid, fifo_rd_en, busy, rx_done, timeout_flag,
                                out_err_start, out_err_parity, out_err_stop, out_data}), 32'd0);
    sb.delete();
    tick();
    PRESET = 1'b0;
    repeat (3) tick();
    chk("rst_cap_idle", 32'({busy, out_valid}), 32'd0);

    // Reset while in HOLD, consumer stalled
    out_ready = 1'b0;
    sb.push_back({8'h4F, 3'b001});
    push(12'h09E);
    for (int k = 0; k < 20 && !out_valid; k++) tick();
    chk("rst_hold_reached", 32'(out_valid), 32'd1);
    PRESET = 1'b1;
    #1;
    chk("rst_hold_outputs", 32'({out_valid, fifo_rd_en, busy, rx_done, timeout_flag,
                                 out_err_start, out_err_parity, out_err_stop, out_data}), 32'd0);
    sb.delete();
    tick();
    PRESET = 1'b0;
    repeat (3) tick();
    chk("rst_hold_idle", 32'({busy, out_valid}), 32'd0);

    out_ready = 1'b1;
    sb.push_back({8'h78, 3'b000});
    base = rd_cnt;
    push(12'h2F0);
    drain("post_rst_drain");
    chk("post_rst_pops", 32'(rd_cnt - base), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
